// File: rtl/quadrature_paddle.sv
// Quadrature encoder front end for the pong paddles: sync, glitch filter,
// Gray decode, edge-per-click accumulation and a saturating position.
module quadrature_paddle #(
    parameter int WIDTH           = 8,
    parameter int EDGES_PER_CLICK = 4,
    parameter int FILTER_LEN      = 4,
    parameter int MIN             = 0,
    parameter int MAX             = (1 << WIDTH) - 1,
    parameter int INIT            = 0,
    parameter bit INVERT          = 1'b0
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             A,
    input  logic             B,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] COUNT,
    output logic             STEP,
    output logic             DIR,
    output logic             SAT,
    output logic             ERROR
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int SW = (EDGES_PER_CLICK > 1) ? $clog2(EDGES_PER_CLICK) : 1;

    localparam logic [FW-1:0]    F_LAST = FW'(FILTER_LEN - 1);
    localparam logic [SW-1:0]    S_TOP  = SW'(EDGES_PER_CLICK - 1);
    localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    filt;
    logic [1:0]    prev;
    logic [FW-1:0] fcnt [2];
    logic [SW-1:0] sub;

    logic [1:0] diff;
    logic       raw_up;
    logic       raw_dn;
    logic       illegal;
    logic       up_e;
    logic       dn_e;

    // Position of a Gray code along the up sequence 00,01,11,10.
    function automatic logic [1:0] gidx(input logic [1:0] ab);
        unique case (ab)
            2'b00:   gidx = 2'd0;
            2'b01:   gidx = 2'd1;
            2'b11:   gidx = 2'd2;
            default: gidx = 2'd3;
        endcase
    endfunction

    // Two-flop synchroniser for both raw phases.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= {A, B};
            s2 <= s1;
        end
    end

    // Per-phase filter: accept s2 only after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge CLOCK) begin
        for (int i = 0; i < 2; i++) begin
            if (!RESET_N) begin
                filt[i] <= 1'b0;
                fcnt[i] <= '0;
            end else if (s2[i] == filt[i]) begin
                fcnt[i] <= '0;
            end else if (fcnt[i] == F_LAST) begin
                filt[i] <= s2[i];
                fcnt[i] <= '0;
            end else begin
                fcnt[i] <= fcnt[i] + FW'(1);
            end
        end
    end

    // Classify the filtered transition; INVERT swaps the count sense.
    always_comb begin
        diff    = gidx(filt) - gidx(prev);
        raw_up  = (diff == 2'd1);
        raw_dn  = (diff == 2'd3);
        illegal = (diff == 2'd2);
        up_e    = INVERT ? raw_dn : raw_up;
        dn_e    = INVERT ? raw_up : raw_dn;
    end

    // Sub-count accumulation, saturating position and registered status outputs.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            prev  <= 2'b00;
            sub   <= '0;
            COUNT <= INIT_V;
            STEP  <= 1'b0;
            SAT   <= 1'b0;
            DIR   <= 1'b0;
            ERROR <= 1'b0;
        end else begin
            prev <= filt;
            STEP <= 1'b0;
            SAT  <= 1'b0;
            if (CLEAR) begin
                COUNT <= INIT_V;
                sub   <= '0;
                ERROR <= 1'b0;
            end else if (illegal) begin
                ERROR <= 1'b1;
            end else if (up_e) begin
                DIR <= 1'b1;
                if (sub == S_TOP) begin
                    sub <= '0;
                    if (COUNT == MAX_V) begin
                        SAT <= 1'b1;
                    end else begin
                        COUNT <= COUNT + WIDTH'(1);
                        STEP  <= 1'b1;
                    end
                end else begin
                    sub <= sub + SW'(1);
                end
            end else if (dn_e) begin
                DIR <= 1'b0;
                if (sub == '0) begin
                    sub <= S_TOP;
                    if (COUNT == MIN_V) begin
                        SAT <= 1'b1;
                    end else begin
                        COUNT <= COUNT - WIDTH'(1);
                        STEP  <= 1'b1;
                    end
                end else begin
                    sub <= sub - SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_quadrature_paddle.sv
// Scoreboard bench for quadrature_paddle: three instances cover the
// default build, a saturating window and a 1-edge inverted variant.
module tb_quadrature_paddle;

    logic CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    logic       RESET_N;
    logic       a   [3];
    logic       b   [3];
    logic       clr [3];
    logic [7:0] cnt [3];
    logic       step[3];
    logic       sat [3];
    logic       dir [3];
    logic       err [3];

    quadrature_paddle u0 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .A(a[0]), .B(b[0]),
        .CLEAR(clr[0]), .COUNT(cnt[0]), .STEP(step[0]), .DIR(dir[0]),
        .SAT(sat[0]), .ERROR(err[0])
    );

    quadrature_paddle #(.MIN(2), .MAX(5), .INIT(4)) u1 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .A(a[1]), .B(b[1]),
        .CLEAR(clr[1]), .COUNT(cnt[1]), .STEP(step[1]), .DIR(dir[1]),
        .SAT(sat[1]), .ERROR(err[1])
    );

    quadrature_paddle #(.EDGES_PER_CLICK(1), .INVERT(1'b1), .INIT(100)) u2 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .A(a[2]), .B(b[2]),
        .CLEAR(clr[2]), .COUNT(cnt[2]), .STEP(step[2]), .DIR(dir[2]),
        .SAT(sat[2]), .ERROR(err[2])
    );

    int p_e   [3] = '{4, 4, 1};
    int p_min [3] = '{0, 2, 0};
    int p_max [3] = '{255, 5, 255};
    int p_init[3] = '{0, 4, 100};
    bit p_inv [3] = '{1'b0, 1'b0, 1'b1};

    logic [1:0] m_ab [3];
    int         m_sub[3];
    int         m_cnt[3];
    logic       m_dir[3];

    typedef struct {
        int inst;
        bit is_sat;
        int count;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int step_seen[3] = '{0, 0, 0};
    int sat_seen [3] = '{0, 0, 0};

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Pop and compare an expected event for every STEP/SAT pulse seen.
    always @(negedge CLOCK) begin
        if (RESET_N === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (step[i] === 1'b1 || sat[i] === 1'b1) begin
                    if (step[i] === 1'b1) step_seen[i]++;
                    else sat_seen[i]++;
                    vectors++;
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL pulse_unexpected inst=%0d step=%b sat=%b cnt=%0d cyc=%0d required none",
                                 i, step[i], sat[i], cnt[i], cyc);
                    end else begin
                        mon_e = sbq.pop_front();
                        if (mon_e.inst != i || (step[i] === 1'b1 && sat[i] === 1'b1) ||
                            mon_e.is_sat != (sat[i] === 1'b1) ||
                            mon_e.count != int'(cnt[i]) || mon_e.cyc != cyc) begin
                            miscompares++;
                            $display("FAIL pulse inst=%0d step=%b sat=%b cnt=%0d cyc=%0d required inst=%0d sat=%b cnt=%0d cyc=%0d",
                                     i, step[i], sat[i], cnt[i], cyc,
                                     mon_e.inst, mon_e.is_sat, mon_e.count, mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [1:0] gnext(input logic [1:0] ab, input bit up);
        case (ab)
            2'b00:   gnext = up ? 2'b01 : 2'b10;
            2'b01:   gnext = up ? 2'b11 : 2'b00;
            2'b11:   gnext = up ? 2'b10 : 2'b01;
            default: gnext = up ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic drive_edge(input int i, input bit up);
        logic [1:0] nab;
        bit         eff;
        bit         click;
        exp_t       e;
        @(negedge CLOCK);
        nab     = gnext(m_ab[i], up);
        a[i]    = nab[1];
        b[i]    = nab[0];
        m_ab[i] = nab;
        eff      = up ^ p_inv[i];
        m_dir[i] = eff;
        click    = 1'b0;
        if (eff) begin
            if (m_sub[i] == p_e[i] - 1) begin
                m_sub[i] = 0;
                click    = 1'b1;
            end else begin
                m_sub[i]++;
            end
        end else begin
            if (m_sub[i] == 0) begin
                m_sub[i] = p_e[i] - 1;
                click    = 1'b1;
            end else begin
                m_sub[i]--;
            end
        end
        if (click) begin
            e.inst = i;
            e.cyc  = cyc + 7;
            if (eff ? (m_cnt[i] == p_max[i]) : (m_cnt[i] == p_min[i])) begin
                e.is_sat = 1'b1;
            end else begin
                m_cnt[i] = m_cnt[i] + (eff ? 1 : -1);
                e.is_sat = 1'b0;
            end
            e.count = m_cnt[i];
            sbq.push_back(e);
        end
    endtask

    task automatic spaced_edges(input int i, input bit up, input int n);
        for (int k = 0; k < n; k++) begin
            drive_edge(i, up);
            repeat (9) @(negedge CLOCK);
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a[i] = 1'b0; b[i] = 1'b0; clr[i] = 1'b0;
            m_ab[i] = 2'b00; m_sub[i] = 0;
            m_cnt[i] = p_init[i]; m_dir[i] = 1'b0;
        end
        repeat (2) @(negedge CLOCK);
        RESET_N = 1'b1;
        @(negedge CLOCK);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (int'(cnt[i]) !== p_init[i] || step[i] !== 1'b0 || sat[i] !== 1'b0 ||
                err[i] !== 1'b0 || dir[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset inst=%0d cnt=%0d step=%b sat=%b err=%b dir=%b required cnt=%0d and zeros",
                         i, cnt[i], step[i], sat[i], err[i], dir[i], p_init[i]);
            end
        end
    endtask

    task automatic test_up_count;
        int s0;
        s0 = step_seen[0];
        for (int k = 0; k < 16; k++) begin
            drive_edge(0, 1'b1);
            repeat (9) @(negedge CLOCK);
            vectors++;
            if (dir[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL up_dir edge=%0d dir=%b required 1", k, dir[0]);
            end
        end
        vectors++;
        if (cnt[0] !== 8'd4 || step_seen[0] - s0 != 4 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL up_count cnt=%0d steps=%0d pending=%0d required cnt=4 steps=4 pending=0",
                     cnt[0], step_seen[0] - s0, sbq.size());
        end
    endtask

    task automatic test_filter_round_trip;
        int s0;
        s0 = step_seen[0];
        @(negedge CLOCK);
        a[0] = ~a[0];
        repeat (3) @(negedge CLOCK);
        a[0] = ~a[0];
        repeat (10) @(negedge CLOCK);
        vectors++;
        if (int'(cnt[0]) !== m_cnt[0] || err[0] !== 1'b0 || dir[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch cnt=%0d err=%b dir=%b required cnt=%0d err=0 dir=1",
                     cnt[0], err[0], dir[0], m_cnt[0]);
        end
        spaced_edges(0, 1'b1, 3);
        spaced_edges(0, 1'b0, 3);
        vectors++;
        if (cnt[0] !== 8'd4 || step_seen[0] != s0 || dir[0] !== 1'b0 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL round_trip cnt=%0d steps=%0d dir=%b required cnt=4 steps=0 dir=0",
                     cnt[0], step_seen[0] - s0, dir[0]);
        end
    endtask

    task automatic test_saturation;
        int s0;
        int t0;
        s0 = step_seen[1];
        t0 = sat_seen[1];
        spaced_edges(1, 1'b1, 32);
        vectors++;
        if (cnt[1] !== 8'd5 || step_seen[1] - s0 != 1 || sat_seen[1] - t0 != 7) begin
            miscompares++;
            $display("FAIL sat_up cnt=%0d steps=%0d sats=%0d required 5 1 7",
                     cnt[1], step_seen[1] - s0, sat_seen[1] - t0);
        end
        spaced_edges(1, 1'b0, 40);
        vectors++;
        if (cnt[1] !== 8'd2 || int'(cnt[1]) !== m_cnt[1] || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL sat_down cnt=%0d pending=%0d required cnt=2 pending=0",
                     cnt[1], sbq.size());
        end
    endtask

    task automatic test_illegal;
        @(negedge CLOCK);
        a[0] = ~a[0];
        b[0] = ~b[0];
        m_ab[0] = m_ab[0] ^ 2'b11;
        repeat (10) @(negedge CLOCK);
        vectors++;
        if (err[0] !== 1'b1 || int'(cnt[0]) !== m_cnt[0] || dir[0] !== m_dir[0]) begin
            miscompares++;
            $display("FAIL illegal err=%b cnt=%0d dir=%b required err=1 cnt=%0d dir=%b",
                     err[0], cnt[0], dir[0], m_cnt[0], m_dir[0]);
        end
        clr[0] = 1'b1;
        @(negedge CLOCK);
        clr[0] = 1'b0;
        m_cnt[0] = p_init[0];
        m_sub[0] = 0;
        @(negedge CLOCK);
        vectors++;
        if (err[0] !== 1'b0 || cnt[0] !== 8'd0) begin
            miscompares++;
            $display("FAIL clear_err err=%b cnt=%0d required err=0 cnt=0", err[0], cnt[0]);
        end
        spaced_edges(0, 1'b1, 4);
        vectors++;
        if (cnt[0] !== 8'd1 || err[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL post_clear cnt=%0d err=%b required cnt=1 err=0", cnt[0], err[0]);
        end
    endtask

    task automatic test_invert_e1;
        for (int k = 0; k < 4; k++) begin
            drive_edge(2, 1'b1);
            repeat (9) @(negedge CLOCK);
            vectors++;
            if (int'(cnt[2]) !== 99 - k || dir[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL invert edge=%0d cnt=%0d dir=%b required cnt=%0d dir=0",
                         k, cnt[2], dir[2], 99 - k);
            end
        end
    endtask

    task automatic test_clear_click;
        exp_t dropped;
        drive_edge(2, 1'b1);
        dropped = sbq.pop_back();
        m_cnt[2] = p_init[2];
        m_sub[2] = 0;
        repeat (6) @(negedge CLOCK);
        clr[2] = 1'b1;
        @(negedge CLOCK);
        clr[2] = 1'b0;
        vectors++;
        if (step[2] !== 1'b0 || sat[2] !== 1'b0 || cnt[2] !== 8'd100) begin
            miscompares++;
            $display("FAIL clear_click step=%b sat=%b cnt=%0d required step=0 sat=0 cnt=100 (dropped %0d)",
                     step[2], sat[2], cnt[2], dropped.count);
        end
        repeat (5) @(negedge CLOCK);
        vectors++;
        if (cnt[2] !== 8'd100 || sbq.size() != 0) begin
            miscompares++;
            $display("FAIL clear_hold cnt=%0d pending=%0d required cnt=100 pending=0",
                     cnt[2], sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_filter_round_trip();
        test_saturation();
        test_illegal();
        test_invert_e1();
        test_clear_click();
        repeat (10) @(negedge CLOCK);
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
